// File: rtl/apb_event_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module : apb_event_counter_pkg
// Brief  : Shared register offsets, CTRL bit positions and the CTRL write
//          decode type for the APB event counter bank.
// Rev    : 1.0  initial release
// ============================================================================
package apb_event_counter_pkg;

    // Register byte offsets inside the 4 KiB APB window
    localparam logic [11:0] CTRL_OFFS     = 12'h000;
    localparam logic [11:0] CH_EN_OFFS    = 12'h004;
    localparam logic [11:0] SAT_OFFS      = 12'h008;
    localparam logic [11:0] OVF_OFFS      = 12'h00C;
    localparam logic [11:0] IRQ_MASK_OFFS = 12'h010;
    localparam logic [11:0] SNAP_BASE     = 12'h040;  // SNAP_LO[i] at +8*i, SNAP_HI[i] at +8*i+4

    // CTRL register bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_SNAP_BIT = 1;
    localparam int CTRL_CLR_BIT  = 2;

    // Decoded view of a CTRL write (en is level, snap/clr are one-shot)
    typedef struct packed {
        logic clr;
        logic snap;
        logic en;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/event_counter_slice.sv
`default_nettype none
// ============================================================================
// Module : event_counter_slice
// Brief  : One event counter channel with wrap/saturate behaviour, a
//          snapshot register and an overflow pulse.
// Rev    : 1.0  initial release
// Ports  : clk, rst     clock, asynchronous active-high reset
//          i_inc        count one this cycle
//          i_clr        clear counter (and snapshot unless i_snap)
//          i_sat        1 = saturate at all ones, 0 = wrap to zero
//          i_snap       copy the current (pre-increment) count to o_snap
//          o_cnt        live count
//          o_snap       snapshot value
//          o_ovf_set    pulse: an increment was attempted at all ones
// ============================================================================
module event_counter_slice
    import apb_event_counter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    input  logic             i_sat,
    input  logic             i_snap,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_snap,
    output logic             o_ovf_set
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_snap;
    logic             w_at_max;

    assign w_at_max  = &r_cnt;
    // A clear swallows the same-cycle event, so it cannot overflow either
    assign o_ovf_set = i_inc & w_at_max & ~i_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_snap <= '0;
        end else begin
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_inc) begin
                if (!w_at_max) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (!i_sat) begin
                    r_cnt <= '0;
                end
            end
            // Snapshot takes the old count even when a clear happens on the
            // same edge; only a clear without snapshot zeroes it.
            if (i_snap) begin
                r_snap <= r_cnt;
            end else if (i_clr) begin
                r_snap <= '0;
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_snap = r_snap;

endmodule
`default_nettype wire

// File: rtl/apb_event_counter_bank.sv
`default_nettype none
// ============================================================================
// Module : apb_event_counter_bank
// Brief  : NUM_CNT event counters of CNT_W bits behind a zero-wait-state APB
//          slave: global/per-channel enable, wrap/saturate, W1C overflow
//          flags and an atomic snapshot of all channels.
// Rev    : 1.0  initial release
// Config : EVCNT_OVF_IRQ_EN  when defined, adds IRQ_MASK (0x10) and drives
//          irq_o = registered |(OVF & IRQ_MASK); otherwise 0x10 is unmapped
//          and irq_o is tied low.
// Ports  : clk_i, rst_i           clock, asynchronous active-high reset
//          paddr_i .. pwdata_i    APB request (offset from paddr_i[11:0])
//          prdata_o               read data, 0 when psel_i is low
//          pready_o               always 1
//          pslverr_o              unmapped / read-only write / disabled reg
//          event_i[NUM_CNT]       per-cycle event pulses
//          irq_o                  overflow interrupt, level
// ============================================================================
module apb_event_counter_bank
    import apb_event_counter_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int NUM_CNT        = 4,
    parameter int CNT_W          = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [31:0]               pwdata_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    input  logic [NUM_CNT-1:0]        event_i,
    output logic                      irq_o
);

    generate
        if (APB_DATA_WIDTH != 32) begin : g_bad_data_width
            $error("apb_event_counter_bank: APB_DATA_WIDTH must be 32");
        end
        if (NUM_CNT < 1 || NUM_CNT > 32) begin : g_bad_num_cnt
            $error("apb_event_counter_bank: NUM_CNT must be 1..32");
        end
        if (CNT_W < 1 || CNT_W > 64) begin : g_bad_cnt_w
            $error("apb_event_counter_bank: CNT_W must be 1..64");
        end
    endgenerate

    localparam logic [11:0] SNAP_SPAN = 12'(8 * NUM_CNT);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [11:0] w_offs;
    logic [11:0] w_snap_rel;
    logic [8:0]  w_snap_idx;
    logic        w_access;
    logic        w_hit_ctrl, w_hit_ch_en, w_hit_sat, w_hit_ovf;
    logic        w_hit_irq_mask, w_hit_snap;
    logic        w_mapped, w_read_only, w_wr;

    assign w_offs      = paddr_i[11:0];
    assign w_access    = psel_i & penable_i;
    assign w_hit_ctrl  = (w_offs == CTRL_OFFS);
    assign w_hit_ch_en = (w_offs == CH_EN_OFFS);
    assign w_hit_sat   = (w_offs == SAT_OFFS);
    assign w_hit_ovf   = (w_offs == OVF_OFFS);
    assign w_snap_rel  = w_offs - SNAP_BASE;
    assign w_snap_idx  = w_snap_rel[11:3];
    assign w_hit_snap  = (w_offs >= SNAP_BASE) && (w_snap_rel < SNAP_SPAN) &&
                         (w_snap_rel[1:0] == 2'b00);

    assign w_mapped    = w_hit_ctrl | w_hit_ch_en | w_hit_sat | w_hit_ovf |
                         w_hit_irq_mask | w_hit_snap;
    assign w_read_only = w_hit_snap;

    // Erroring accesses must not touch state, so writes are qualified here
    assign pslverr_o   = w_access & (~w_mapped | (pwrite_i & w_read_only));
    assign w_wr        = w_access & pwrite_i & w_mapped & ~w_read_only;
    assign pready_o    = 1'b1;

    ctrl_t w_ctrl_wr;
    always_comb begin
        w_ctrl_wr      = '0;
        w_ctrl_wr.en   = pwdata_i[CTRL_EN_BIT];
        w_ctrl_wr.snap = pwdata_i[CTRL_SNAP_BIT];
        w_ctrl_wr.clr  = pwdata_i[CTRL_CLR_BIT];
    end

    logic w_snap_pulse, w_clr_pulse;
    assign w_snap_pulse = w_wr & w_hit_ctrl & w_ctrl_wr.snap;
    assign w_clr_pulse  = w_wr & w_hit_ctrl & w_ctrl_wr.clr;

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    logic               r_en;
    logic [NUM_CNT-1:0] r_ch_en;
    logic [NUM_CNT-1:0] r_sat;
    logic [NUM_CNT-1:0] r_ovf;
    logic [NUM_CNT-1:0] w_ovf_set;
    logic [NUM_CNT-1:0] w_ovf_clr;

    assign w_ovf_clr = (w_wr && w_hit_ovf) ? pwdata_i[NUM_CNT-1:0] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_en    <= 1'b0;
            r_ch_en <= '1;
            r_sat   <= '0;
            r_ovf   <= '0;
        end else begin
            if (w_wr && w_hit_ctrl) begin
                r_en <= w_ctrl_wr.en;
            end
            if (w_wr && w_hit_ch_en) begin
                r_ch_en <= pwdata_i[NUM_CNT-1:0];
            end
            if (w_wr && w_hit_sat) begin
                r_sat <= pwdata_i[NUM_CNT-1:0];
            end
            // Set is applied after clear so a same-cycle overflow survives W1C
            r_ovf <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
        end
    end

`ifdef EVCNT_OVF_IRQ_EN
    logic [NUM_CNT-1:0] r_irq_mask;
    logic               r_irq;

    assign w_hit_irq_mask = (w_offs == IRQ_MASK_OFFS);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr && w_hit_irq_mask) begin
                r_irq_mask <= pwdata_i[NUM_CNT-1:0];
            end
            r_irq <= |(r_ovf & r_irq_mask);
        end
    end

    assign irq_o = r_irq;
`else
    assign w_hit_irq_mask = 1'b0;
    assign irq_o          = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Counter channels
    // ------------------------------------------------------------------
    logic [NUM_CNT-1:0]            w_inc;
    logic [NUM_CNT-1:0][CNT_W-1:0] w_cnt;
    logic [NUM_CNT-1:0][CNT_W-1:0] w_snap;
    logic [NUM_CNT-1:0][63:0]      w_snap_ext;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_slice
            assign w_inc[gi] = event_i[gi] & r_en & r_ch_en[gi];

            event_counter_slice #(
                .CNT_W (CNT_W)
            ) u_slice (
                .clk       (clk_i),
                .rst       (rst_i),
                .i_inc     (w_inc[gi]),
                .i_clr     (w_clr_pulse),
                .i_sat     (r_sat[gi]),
                .i_snap    (w_snap_pulse),
                .o_cnt     (w_cnt[gi]),
                .o_snap    (w_snap[gi]),
                .o_ovf_set (w_ovf_set[gi])
            );

            // Zero-extended so SNAP_HI reads 0 for narrow counters
            assign w_snap_ext[gi] = 64'(w_snap[gi]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        if (w_hit_ctrl) begin
            w_rdata[CTRL_EN_BIT] = r_en;
        end
        if (w_hit_ch_en) begin
            w_rdata = 32'(r_ch_en);
        end
        if (w_hit_sat) begin
            w_rdata = 32'(r_sat);
        end
        if (w_hit_ovf) begin
            w_rdata = 32'(r_ovf);
        end
`ifdef EVCNT_OVF_IRQ_EN
        if (w_hit_irq_mask) begin
            w_rdata = 32'(r_irq_mask);
        end
`endif
        if (w_hit_snap) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (w_snap_idx == 9'(i)) begin
                    w_rdata = w_snap_rel[2] ? w_snap_ext[i][63:32] : w_snap_ext[i][31:0];
                end
            end
        end
    end

    assign prdata_o = psel_i ? w_rdata : '0;

    // Address bits above the 4 KiB window, unused write-data bits and the
    // live counts are intentionally not observed.
    logic w_unused;
    assign w_unused = &{1'b0, paddr_i, pwdata_i, w_cnt};

endmodule
`default_nettype wire
